uart_rx_os16: RTL and testbench

Oversampling UART receiver for the serial input side of the UART subsystem. It is self-timed from a single system clock and does not use the shared baud generator. It samples the `rx` line at 16x the baud rate, validates the start bit, and recovers 8-bit LSB-first frames by majority vote. It reports framing, parity and break conditions alongside a one-cycle data-valid strobe.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_os_tick.sv | 36 +++
 rtl/uart_rx_os16.sv | 157 +++++++++++++++
 tb/tb_uart_rx_os16.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART blocks: receiver state codes,
// parity mode encoding and the 16x tick divisor calculation.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] BRK   = 3'd5;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, truncated; callers must keep the result >= 1.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divisor: counts 0..DIV-1 and pulses tick at DIV-1.
// While restart is high the counter is held at 0 and no tick is issued.
module uart_os_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = !restart && (cnt_q == LAST);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values computed in always_comb.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: start validation, 3-sample majority vote,
// LSB-first 8-bit frames with optional parity, framing and break reporting.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_val,
    output logic       frame_err,
    output logic       parity_err,
    output logic       break_det,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    logic       rx_meta_q, rx_meta_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [2:0] state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic       par_err_q, par_err_d;
    logic       rx_val_q, rx_val_d, frame_err_q, frame_err_d;
    logic       parity_err_q, parity_err_d, break_q, break_d;
    logic       tick, fall, vote, mid, bit_end;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == IDLE),
        .tick    (tick)
    );

    assign fall    = rxs_prev_q && !rxs_q;
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign mid     = tick && (sc_q == 4'd9);
    assign bit_end = tick && (sc_q == 4'd15);

    always_comb begin
        rx_meta_d    = rx;
        rxs_d        = rx_meta_q;
        rxs_prev_d   = rxs_q;
        state_d      = state_q;
        sc_d         = tick ? sc_q + 4'd1 : sc_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        rx_data_d    = rx_data_q;
        rx_val_d     = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        break_d      = 1'b0;

        if (tick && sc_q == 4'd7) samp_d[0] = rxs_q;
        if (tick && sc_q == 4'd8) samp_d[1] = rxs_q;

        case (state_q)
            IDLE: begin
                sc_d      = '0;
                bit_cnt_d = '0;
                par_err_d = 1'b0;
                if (fall) state_d = START;
            end
            START: begin
                if (mid && vote)  state_d = IDLE;
                else if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (mid) shift_d = {vote, shift_q[7:1]};
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = (PARITY != PAR_NONE) ? PAR : STOP;
                end
            end
            PAR: begin
                if (mid) begin
                    par_err_d = (PARITY == PAR_EVEN) ? (vote != ^shift_q) : (vote != ~^shift_q);
                end
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // bit_cnt_q has wrapped to 0 here; 1 marks the optional second stop bit.
                if (mid && bit_cnt_q == 3'd0) begin
                    rx_val_d     = 1'b1;
                    rx_data_d    = shift_q;
                    frame_err_d  = !vote;
                    parity_err_d = par_err_q;
                    if (!vote && shift_q == 8'h00) begin
                        break_d = 1'b1;
                        state_d = BRK;
                    end else if (STOP_BITS == 1) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = 3'd1;
                    end
                end else if (mid) begin
                    state_d = IDLE;
                end
            end
            BRK: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= IDLE;
            sc_q         <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_val_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_val_q     <= rx_val_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_val     = rx_val_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench: directed cases plus randomized frames on an 8N1 receiver
// and an even-parity receiver, compared against a frame-level reference model.
module tb_uart_rx_os16;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic val_a, fe_a, pe_a, brk_a, busy_a;
    logic val_b, fe_b, pe_b, brk_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int brk_cnt_a = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
    } ev_t;

    ev_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];

    always #5 clk = ~clk;

    uart_rx_os16 #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_val(val_a),
        .frame_err(fe_a), .parity_err(pe_a), .break_det(brk_a), .busy(busy_a)
    );

    uart_rx_os16 #(.CLK_FREQ(16_000_000), .BAUD(1_000_000), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_val(val_b),
        .frame_err(fe_b), .parity_err(pe_b), .break_det(brk_b), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (val_a) obs_a.push_back(ev_t'({data_a, fe_a, pe_a, brk_a}));
        if (val_b) obs_b.push_back(ev_t'({data_b, fe_b, pe_b, brk_b}));
        if (brk_a) brk_cnt_a++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the frame as the line carried it, judged by the protocol rules.
    function automatic ev_t model(input logic [7:0] d, input bit has_par,
                                  input bit par_bit, input bit stop_bit);
        ev_t e;
        e.data = d;
        e.fe   = !stop_bit;
        e.pe   = has_par && (par_bit != (^d));
        e.brk  = !stop_bit && (d == 8'h00);
        return e;
    endfunction

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic hold(input bit sel, input logic v, input int clks);
        drive(sel, v);
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input bit par_bit, input bit stop_bit);
        hold(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(sel, d[i], BIT);
        if (use_par) hold(sel, par_bit, BIT);
        hold(sel, stop_bit, BIT);
        drive(sel, 1'b1);
    endtask

    task automatic check_events(input bit sel, input string tag);
        ev_t o[$], e[$];
        int n;
        if (sel) begin
            o = obs_b; e = exp_b; obs_b.delete(); exp_b.delete();
        end else begin
            o = obs_a; e = exp_a; obs_a.delete(); exp_a.delete();
        end
        check({tag, "_count"}, o.size(), e.size());
        n = (o.size() < e.size()) ? o.size() : e.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d{data,fe,pe,brk}", tag, i), 32'(o[i]), 32'(e[i]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        bit stop_bit, par_bit;
        int gap;

        repeat (4) @(negedge clk);
        check("reset_a_outputs", {data_a, val_a, fe_a, pe_a, brk_a, busy_a}, 32'h0);
        check("reset_b_outputs", {data_b, val_b, fe_b, pe_b, brk_b, busy_b}, 32'h0);
        rst = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Clean 8N1 frame with busy observed across the frame.
        exp_a.push_back(model(8'hA5, 1'b0, 1'b0, 1'b1));
        hold(0, 1'b0, 4);
        check("a5_busy_start", busy_a, 1'b1);
        hold(0, 1'b0, BIT - 4);
        for (int i = 0; i < 8; i++) hold(0, 8'hA5 >> i, BIT);
        check("a5_busy_data", busy_a, 1'b1);
        hold(0, 1'b1, BIT);
        check("a5_busy_after_stop", busy_a, 1'b0);
        hold(0, 1'b1, 2 * BIT);
        check_events(0, "a5");
        check("a5_rx_data_hold", data_a, 8'hA5);

        // Short low glitch must not start a frame.
        hold(0, 1'b0, 4);
        check("glitch_busy_high", busy_a, 1'b1);
        hold(0, 1'b1, 16);
        check("glitch_busy_low", busy_a, 1'b0);
        hold(0, 1'b1, BIT);
        check_events(0, "glitch");

        // Even parity: wrong then right parity bit for 0x03.
        exp_b.push_back(model(8'h03, 1'b1, 1'b1, 1'b1));
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
        hold(1, 1'b1, 2 * BIT);
        exp_b.push_back(model(8'h03, 1'b1, 1'b0, 1'b1));
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        hold(1, 1'b1, 2 * BIT);
        check_events(1, "parity03");

        // Framing error without break.
        exp_a.push_back(model(8'h3C, 1'b0, 1'b0, 1'b0));
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        hold(0, 1'b1, 2 * BIT);
        check_events(0, "frame_err3c");

        // Break: line low for 30 bit times, then a normal frame.
        brk_cnt_a = 0;
        exp_a.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
        hold(0, 1'b0, 30 * BIT);
        check("break_busy_held", busy_a, 1'b1);
        check("break_pulses_low", brk_cnt_a, 1);
        hold(0, 1'b1, 2 * BIT);
        check("break_busy_released", busy_a, 1'b0);
        check_events(0, "break");
        exp_a.push_back(model(8'h55, 1'b0, 1'b0, 1'b1));
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * BIT);
        check_events(0, "after_break55");
        check("break_pulses_total", brk_cnt_a, 1);

        // Back-to-back frames with no idle gap.
        exp_a.push_back(model(8'h12, 1'b0, 1'b0, 1'b1));
        exp_a.push_back(model(8'h34, 1'b0, 1'b0, 1'b1));
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * BIT);
        check_events(0, "b2b");

        // Reset in the middle of the data bits.
        hold(0, 1'b0, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b0, BIT / 2);
        check("pre_reset_busy", busy_a, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_a_outputs", {data_a, val_a, fe_a, pe_a, brk_a, busy_a}, 32'h0);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        hold(0, 1'b1, 2 * BIT);
        obs_a.delete();
        exp_a.push_back(model(8'h96, 1'b0, 1'b0, 1'b1));
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
        hold(0, 1'b1, 2 * BIT);
        check_events(0, "post_reset96");

        // Randomized traffic on both receivers.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 20; k++) begin
                d        = 8'($urandom);
                stop_bit = ($urandom_range(0, 5) != 0);
                par_bit  = (^d) ^ ($urandom_range(0, 3) == 0);
                gap      = $urandom_range(0, 2);
                if (!stop_bit && gap == 0) gap = 1;
                if (s == 1) exp_b.push_back(model(d, 1'b1, par_bit, stop_bit));
                else        exp_a.push_back(model(d, 1'b0, 1'b0, stop_bit));
                send_frame(s[0], d, s[0], par_bit, stop_bit);
                hold(s[0], 1'b1, gap * BIT);
            end
            hold(s[0], 1'b1, 2 * BIT);
            check_events(s[0], (s == 1) ? "rand_par" : "rand_8n1");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
